sevenseg_scan_decoder: RTL and testbench
========================================

Name: sevenseg_scan_decoder

Overview:
- Listens to a multiplexed 4-digit, common-anode, active-low seven-segment bus and reconstructs the 16-bit hex value being displayed.
- It is the receive-side counterpart of the hex-to-segment encoders and display drivers. It is used for self-checking display paths and for loopback between boards.
- It qualifies each anode/segment pair over several stable samples, decodes the pattern back to a nibble, flags patterns that are not legal hex glyphs, and reports frame completion and stale-display timeout.

Parameters:
- SETTLE, 4: consecutive identical samples required before a digit is accepted (legal range 2..255).
- STALE_CYCLES, 1000000: cycles without any accepted digit before the display is declared stale (legal range 1..2^24-1).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- D1_seg  input  8  segment bus, active-low. Bit 7 = dp; bits 6..0 = g,f,e,d,c,b,a. Synchronous to clk.
- D1_a  input  4  anode selects, active-low. Bit i low selects digit i.
- value  output  16  decoded nibbles; digit i maps to value[4i+3:4i].
- digit_valid  output  4  bit i = slot i holds a legal decoded glyph.
- seg_err  output  4  bit i = last accepted pattern for digit i was illegal.
- dp  output  4  bit i = decimal point lit on the last accepted sample of digit i.
- update  output  1  one-cycle pulse on each accepted digit.
- frame_done  output  1  one-cycle pulse when all four digits have been accepted since the previous frame_done.
- stale  output  1  level; display has been silent for STALE_CYCLES cycles.

Behaviour:
- Reset (async): all outputs are 0, all internal registers are 0, and the FSM is in IDLE. Reset asserted mid-qualification discards the partial sample; nothing is committed.
- Input register: {D1_a, D1_seg} is registered every clk into r_pair. The comparison is between r_pair and its previous value.
- Valid select: D1_a has exactly one bit low. All-high, or more than one bit low, is an invalid select.
- FSM:
  - IDLE: entered on reset or when r_pair holds an invalid select. Go to SETTLE with cnt=1 on the first valid select.
  - SETTLE:
    - If r_pair changes: go to SETTLE with cnt=1 if the new select is valid, else IDLE.
    - Otherwise cnt increments. When cnt reaches SETTLE, commit and go to HOLD.
  - HOLD: stays while r_pair is unchanged; no re-commit. On any change, behave as SETTLE's change rule.
- Latency: a pair applied before edge k and held stable produces a commit on edge k+SETTLE. update is high for the cycle following that edge, and the outputs change on that same edge.
- Commit of digit i with pattern p = seg[6:0]:
  - Legal table:
    - 0x40->0, 0x79->1, 0x24->2, 0x30->3
    - 0x19->4, 0x12->5, 0x02->6, 0x78->7
    - 0x00->8, 0x10->9, 0x08->A, 0x03->B
    - 0x46->C, 0x21->D, 0x06->E, 0x0E->F
  - Legal: write the nibble, set digit_valid[i]=1, seg_err[i]=0.
  - Blank (0x7F): nibble unchanged, digit_valid[i]=0, seg_err[i]=0.
  - Any other pattern: nibble unchanged, digit_valid[i]=0, seg_err[i]=1.
  - In all three cases dp[i] = ~seg[7].
  - Each commit, including blank and illegal ones, pulses update, sets seen[i], clears stale, and zeroes stale_cnt.
- Frame: when a commit makes seen==4'b1111, frame_done pulses in the same cycle as update and seen clears to 0. A repeated commit of the same digit does not complete a frame.
- Stale:
  - stale_cnt increments every cycle without a commit and saturates at STALE_CYCLES.
  - On reaching STALE_CYCLES: stale=1, digit_valid=0, seen=0. value, seg_err and dp are retained.
  - If a commit and the threshold occur in the same cycle, the commit wins and stale stays 0.
- Widths: cnt is 8 bits and saturating; stale_cnt is 24 bits. There is no wrap-around.

Test Plan:
- Hold D1_a=4'b1110, D1_seg=8'hC0 for 10 cycles (SETTLE=4) -> one update pulse on edge k+4; value[3:0]=0, digit_valid=4'b0001, dp[0]=0; no further pulses.
- Scan digits 0..3 with 0xF9, 0xA4, 0xB0, 0x99, 6 cycles each -> four update pulses, value=16'h4321, digit_valid=4'hF, frame_done coincident with the 4th update only.
- Glitch: digit 2 with 0x92 for 3 cycles, then 0x82 for 6 cycles -> single commit, value[11:8]=6. Glitch shorter than SETTLE never commits.
- D1_seg=8'h7F on digit 1 -> digit_valid[1]=0, seg_err[1]=0; D1_seg=8'h55 -> seg_err[1]=1, nibble unchanged; D1_seg=8'h40 (dp lit, 0) -> dp[1]=1, seg_err[1]=0.
- D1_a=4'b1100 or 4'b1111 held 20 cycles -> no update. STALE_CYCLES=16 with no commits -> stale=1 at cycle 16 and digit_valid=0; next valid commit -> stale=0.
- Assert rst at cnt=3 on a stable digit, then release with inputs unchanged -> all outputs 0, and the commit occurs SETTLE samples after release.

Source files
------------

// File: rtl/sevenseg_scan_decoder_if.sv
// Multiplexed seven-segment display bus: active-low segments plus active-low anode selects.
interface sevenseg_scan_decoder_if;
    logic [7:0] D1_seg;
    logic [3:0] D1_a;

    modport master (output D1_seg, output D1_a);
    modport slave  (input D1_seg, input D1_a);
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Receive-side decoder for a 4-digit common-anode scanned display: qualifies each
// anode/segment pair over SETTLE stable samples and rebuilds the displayed hex value.
module sevenseg_scan_decoder #(
    parameter int SETTLE       = 4,
    parameter int STALE_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    sevenseg_scan_decoder_if.slave        disp,
    output logic [15:0]                   value,
    output logic [3:0]                    digit_valid,
    output logic [3:0]                    seg_err,
    output logic [3:0]                    dp,
    output logic                          update,
    output logic                          frame_done,
    output logic                          stale
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

    localparam logic [7:0]  SETTLE_W = 8'(SETTLE);
    localparam logic [23:0] STALE_W  = 24'(STALE_CYCLES);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [11:0] r_pair, prev_pair;
    logic [3:0]  seen;
    logic [23:0] stale_cnt;
    logic        commit;
    logic        change;
    logic        valid_now;
    logic [3:0]  sel;
    logic [4:0]  decoded;

    function automatic logic one_low(input logic [3:0] a);
        logic [3:0] low;
        low = ~a;
        return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Returns {legal, nibble}; legal=0 for blank and for non-hex glyphs.
    function automatic logic [4:0] glyph(input logic [6:0] p);
        case (p)
            7'h40: glyph = {1'b1, 4'h0};
            7'h79: glyph = {1'b1, 4'h1};
            7'h24: glyph = {1'b1, 4'h2};
            7'h30: glyph = {1'b1, 4'h3};
            7'h19: glyph = {1'b1, 4'h4};
            7'h12: glyph = {1'b1, 4'h5};
            7'h02: glyph = {1'b1, 4'h6};
            7'h78: glyph = {1'b1, 4'h7};
            7'h00: glyph = {1'b1, 4'h8};
            7'h10: glyph = {1'b1, 4'h9};
            7'h08: glyph = {1'b1, 4'hA};
            7'h03: glyph = {1'b1, 4'hB};
            7'h46: glyph = {1'b1, 4'hC};
            7'h21: glyph = {1'b1, 4'hD};
            7'h06: glyph = {1'b1, 4'hE};
            7'h0E: glyph = {1'b1, 4'hF};
            default: glyph = 5'd0;
        endcase
    endfunction

    assign change    = (r_pair != prev_pair);
    assign valid_now = one_low(r_pair[11:8]);
    assign sel       = ~r_pair[11:8];
    assign decoded   = glyph(r_pair[6:0]);

    // Input sampling and qualification state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pair    <= '0;
            prev_pair <= '0;
            state     <= S_IDLE;
            cnt       <= '0;
        end else begin
            r_pair    <= {disp.D1_a, disp.D1_seg};
            prev_pair <= r_pair;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_now) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = 8'd1;
                end
            end
            S_SETTLE, S_HOLD: begin
                if (change) begin
                    if (valid_now) begin
                        state_nxt = S_SETTLE;
                        cnt_nxt   = 8'd1;
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end else if (state == S_SETTLE) begin
                    cnt_nxt = sat_inc8(cnt);
                    if (cnt_nxt == SETTLE_W) begin
                        commit    = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Commit, frame tracking and stale detection; a commit always beats the stale threshold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value       <= '0;
            digit_valid <= '0;
            seg_err     <= '0;
            dp          <= '0;
            update      <= 1'b0;
            frame_done  <= 1'b0;
            stale       <= 1'b0;
            seen        <= '0;
            stale_cnt   <= '0;
        end else begin
            update     <= commit;
            frame_done <= 1'b0;
            if (commit) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        if (decoded[4]) begin
                            value[4*i +: 4] <= decoded[3:0];
                            digit_valid[i]  <= 1'b1;
                            seg_err[i]      <= 1'b0;
                        end else begin
                            digit_valid[i]  <= 1'b0;
                            seg_err[i]      <= (r_pair[6:0] != 7'h7F);
                        end
                        dp[i] <= ~r_pair[7];
                    end
                end
                if ((seen | sel) == 4'hF) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen | sel;
                end
                stale     <= 1'b0;
                stale_cnt <= '0;
            end else if (stale_cnt != STALE_W) begin
                stale_cnt <= stale_cnt + 24'd1;
                if (stale_cnt + 24'd1 == STALE_W) begin
                    stale       <= 1'b1;
                    digit_valid <= '0;
                    seen        <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: directed scenarios plus random scanning, checked
// each cycle against a run-length reference model of the display receiver.
module tb_sevenseg_scan_decoder;
    localparam int SETTLE       = 4;
    localparam int STALE_CYCLES = 16;
    // Legal glyph patterns, nibble 0 in the low 7 bits.
    localparam logic [111:0] GLYPHS = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                       7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value;
    logic [3:0]  digit_valid, seg_err, dp;
    logic        update, frame_done, stale;
    int          n_vec = 0;
    int          n_err = 0;

    sevenseg_scan_decoder_if disp_bus ();

    sevenseg_scan_decoder #(.SETTLE(SETTLE), .STALE_CYCLES(STALE_CYCLES)) dut (
        .clk(clk), .rst(rst), .disp(disp_bus.slave), .value(value),
        .digit_valid(digit_valid), .seg_err(seg_err), .dp(dp), .update(update),
        .frame_done(frame_done), .stale(stale)
    );

    always #5 clk = ~clk;

    // Reference model: a digit is accepted once the sampled pair has been seen on
    // SETTLE consecutive edges with exactly one anode low.
    logic [11:0] m_rpair, m_last;
    int          m_run, m_scnt;
    logic [15:0] m_value;
    logic [3:0]  m_dv, m_err, m_dp, m_seen;
    logic        m_upd, m_fd, m_stale;

    task automatic model_reset();
        m_rpair = '0; m_last = '0; m_run = 0; m_scnt = 0;
        m_value = '0; m_dv = '0; m_err = '0; m_dp = '0; m_seen = '0;
        m_upd = 1'b0; m_fd = 1'b0; m_stale = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] a, input logic [7:0] seg);
        int idx, lows, nib;
        m_run  = (m_rpair == m_last) ? m_run + 1 : 1;
        m_last = m_rpair;
        lows = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!m_rpair[8+i]) begin lows++; idx = i; end
        m_upd = (lows == 1) && (m_run == SETTLE);
        m_fd  = 1'b0;
        if (m_upd) begin
            nib = -1;
            for (int g = 0; g < 16; g++) if (GLYPHS[7*g +: 7] == m_rpair[6:0]) nib = g;
            if (nib >= 0) begin
                m_value[4*idx +: 4] = 4'(nib);
                m_dv[idx] = 1'b1; m_err[idx] = 1'b0;
            end else begin
                m_dv[idx] = 1'b0; m_err[idx] = (m_rpair[6:0] != 7'h7F);
            end
            m_dp[idx]   = ~m_rpair[7];
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin m_fd = 1'b1; m_seen = '0; end
            m_stale = 1'b0; m_scnt = 0;
        end else if (m_scnt < STALE_CYCLES) begin
            m_scnt++;
            if (m_scnt == STALE_CYCLES) begin m_stale = 1'b1; m_dv = '0; m_seen = '0; end
        end
        m_rpair = {a, seg};
    endtask

    function automatic logic [30:0] obs();
        return {value, digit_valid, seg_err, dp, update, frame_done, stale};
    endfunction

    function automatic logic [30:0] expv();
        return {m_value, m_dv, m_err, m_dp, m_upd, m_fd, m_stale};
    endfunction

    task automatic tick(input logic [3:0] a, input logic [7:0] seg);
        disp_bus.D1_a   = a;
        disp_bus.D1_seg = seg;
        @(posedge clk);
        model_edge(a, seg);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        disp_bus.D1_a = 4'hF; disp_bus.D1_seg = 8'hFF;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs() !== 31'd0) begin
            n_err++; $display("FAIL reset_state: got %h want 0", obs());
        end
        rst = 1'b0;
    endtask

    task automatic test_single_digit();
        int n_upd = 0, upd_at = 0;
        do_reset();
        for (int t = 1; t <= 10; t++) begin
            tick(4'b1110, 8'hC0);
            if (update) begin n_upd++; upd_at = t; end
            n_vec++;
            if (obs() !== expv()) begin
                n_err++; $display("FAIL single_cycle%0d: got %h want %h", t, obs(), expv());
            end
        end
        n_vec++;
        if (n_upd != 1 || upd_at != SETTLE + 1) begin
            n_err++; $display("FAIL single_latency: got %0d pulses at tick %0d want 1 at %0d", n_upd, upd_at, SETTLE + 1);
        end
        n_vec++;
        if ({value[3:0], digit_valid, dp[0]} !== {4'h0, 4'b0001, 1'b0}) begin
            n_err++; $display("FAIL single_out: got %h/%b/%b want 0/0001/0", value[3:0], digit_valid, dp[0]);
        end
    endtask

    task automatic test_scan_frame();
        logic [7:0] segs [4];
        int n_upd = 0, n_fd = 0, fd_at = 0;
        segs[0] = 8'hF9; segs[1] = 8'hA4; segs[2] = 8'hB0; segs[3] = 8'h99;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            for (int t = 0; t < 6; t++) begin
                tick(~(4'b0001 << d), segs[d]);
                if (update) n_upd++;
                if (frame_done) begin n_fd++; fd_at = update ? n_upd : -1; end
                n_vec++;
                if (obs() !== expv()) begin
                    n_err++; $display("FAIL scan_cycle: got %h want %h", obs(), expv());
                end
            end
        end
        n_vec++;
        if (n_upd != 4 || n_fd != 1 || fd_at != 4) begin
            n_err++; $display("FAIL scan_pulses: got upd=%0d fd=%0d at=%0d want 4 1 4", n_upd, n_fd, fd_at);
        end
        n_vec++;
        if ({value, digit_valid} !== {16'h4321, 4'hF}) begin
            n_err++; $display("FAIL scan_value: got %h/%h want 4321/f", value, digit_valid);
        end
    endtask

    task automatic test_glitch();
        int n_upd = 0;
        do_reset();
        for (int t = 0; t < 9; t++) begin
            tick(4'b1011, (t < 3) ? 8'h92 : 8'h82);
            if (update) n_upd++;
            n_vec++;
            if (obs() !== expv()) begin
                n_err++; $display("FAIL glitch_cycle: got %h want %h", obs(), expv());
            end
        end
        n_vec++;
        if (n_upd != 1 || value[11:8] !== 4'h6) begin
            n_err++; $display("FAIL glitch_commit: got %0d commits nibble %h want 1 6", n_upd, value[11:8]);
        end
    endtask

    task automatic test_blank_illegal_dp();
        logic [7:0] segs [4];
        logic [6:0] want [4];
        logic [6:0] got;
        // {nibble, digit_valid[1], seg_err[1], dp[1]} after each phase
        segs[0] = 8'hA4; want[0] = {4'h2, 1'b1, 1'b0, 1'b0};
        segs[1] = 8'h7F; want[1] = {4'h2, 1'b0, 1'b0, 1'b1};
        segs[2] = 8'h55; want[2] = {4'h2, 1'b0, 1'b1, 1'b1};
        segs[3] = 8'h40; want[3] = {4'h0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int t = 0; t < 7; t++) begin
                tick(4'b1101, segs[p]);
                n_vec++;
                if (obs() !== expv()) begin
                    n_err++; $display("FAIL glyph_cycle: got %h want %h", obs(), expv());
                end
            end
            got = {value[7:4], digit_valid[1], seg_err[1], dp[1]};
            n_vec++;
            if (got !== want[p]) begin
                n_err++; $display("FAIL glyph_phase%0d: got %h want %h", p, got, want[p]);
            end
        end
    endtask

    task automatic test_invalid_select();
        int n_upd = 0;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            tick((t < 20) ? 4'b1100 : 4'b1111, 8'hC0);
            if (update) n_upd++;
            n_vec++;
            if (obs() !== expv()) begin
                n_err++; $display("FAIL badsel_cycle: got %h want %h", obs(), expv());
            end
        end
        n_vec++;
        if (n_upd != 0 || stale !== 1'b1) begin
            n_err++; $display("FAIL badsel_none: got %0d updates stale=%b want 0 1", n_upd, stale);
        end
    endtask

    task automatic test_stale();
        int since = -1;
        logic want_stale;
        do_reset();
        repeat (6) tick(4'b0111, 8'hC0);
        since = 1;
        n_vec++;
        if (digit_valid !== 4'b1000) begin
            n_err++; $display("FAIL stale_pre: got %b want 1000", digit_valid);
        end
        for (int t = 0; t < 20; t++) begin
            tick(4'b1111, 8'hFF);
            since++;
            want_stale = (since >= STALE_CYCLES);
            n_vec++;
            if ({stale, digit_valid} !== {want_stale, want_stale ? 4'b0000 : 4'b1000}) begin
                n_err++; $display("FAIL stale_level%0d: got %b/%b want %b", since, stale, digit_valid, want_stale);
            end
        end
        for (int t = 0; t < 6; t++) begin
            tick(4'b1110, 8'h79);
            n_vec++;
            if (obs() !== expv()) begin
                n_err++; $display("FAIL stale_cycle: got %h want %h", obs(), expv());
            end
        end
        n_vec++;
        if ({stale, digit_valid, value[3:0]} !== {1'b0, 4'b0001, 4'h1}) begin
            n_err++; $display("FAIL stale_clear: got %b/%b/%h want 0/0001/1", stale, digit_valid, value[3:0]);
        end
    endtask

    task automatic test_reset_mid_settle();
        int upd_at = 0;
        do_reset();
        repeat (6) tick(4'b1110, 8'hF9);
        repeat (4) tick(4'b1011, 8'hB0);
        rst = 1'b1;
        model_reset();
        #2;
        n_vec++;
        if (obs() !== 31'd0) begin
            n_err++; $display("FAIL midreset_state: got %h want 0", obs());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick(4'b1011, 8'hB0);
            if (update && upd_at == 0) upd_at = t;
            n_vec++;
            if (obs() !== expv()) begin
                n_err++; $display("FAIL midreset_cycle: got %h want %h", obs(), expv());
            end
        end
        n_vec++;
        if (upd_at != SETTLE + 1 || value !== 16'h0300) begin
            n_err++; $display("FAIL midreset_commit: got tick %0d value %h want %0d 0300", upd_at, value, SETTLE + 1);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [7:0] seg;
        int len, kind;
        do_reset();
        for (int s = 0; s < 80; s++) begin
            kind = $urandom_range(0, 19);
            a    = ~(4'b0001 << $urandom_range(0, 3));
            seg  = {1'($urandom_range(0, 1)), GLYPHS[7*$urandom_range(0, 15) +: 7]};
            if (kind == 0) a = 4'($urandom_range(0, 15));
            else if (kind == 1) seg = {1'($urandom_range(0, 1)), 7'h7F};
            else if (kind == 2) seg = 8'($urandom_range(0, 255));
            len = (kind == 3) ? 20 : $urandom_range(1, 8);
            for (int t = 0; t < len; t++) begin
                tick(a, seg);
                n_vec++;
                if (obs() !== expv()) begin
                    n_err++; $display("FAIL random_seg%0d: got %h want %h", s, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_digit();
        test_scan_frame();
        test_glitch();
        test_blank_illegal_dp();
        test_invalid_select();
        test_stale();
        test_reset_mid_settle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
